counter_prog: RTL and testbench
===============================

// Module: counter_prog
// PURPOSE
//  Parametrised up/down counter, next generation of the fixed 8-bit enable counter.
//  Adds programmable modulus, an enable prescaler, synchronous load, direction and
//  wrap/saturate mode, a terminal-count strobe and sticky over/underflow flags.
//  Serves as a general timebase/event counter for Kairos EDA example designs.
// PARAMETERS
//  WIDTH  8  counter width in bits (>=2)
//  PRE_W  4  prescaler width; step rate = enabled cycles / (prescale+1)
// PORTS
//  clk         in   1      single clock; all state updates on posedge clk
//  rst_n       in   1      reset, synchronous, active-low
//  enable      in   1      advances the prescaler; counting only while high
//  load        in   1      synchronous load strobe
//  load_value  in   WIDTH  value for load (clamped to modulus)
//  dir         in   1      1 = up, 0 = down
//  saturate    in   1      0 = wrap at limits, 1 = hold at limits
//  modulus     in   WIDTH  terminal value; count range 0..modulus
//  prescale    in   PRE_W  prescaler divide-minus-one (0 = step every enabled cycle)
//  clr_flags   in   1      synchronous clear of ovf/udf
//  count       out  WIDTH  registered count
//  tc          out  1      terminal-count strobe (combinational, same cycle as step)
//  ovf         out  1      sticky: up-count hit modulus while stepping
//  udf         out  1      sticky: down-count hit 0 while stepping
// BEHAVIOUR
//  - Reset (rst_n low at posedge): count=0, pre_cnt=0, ovf=0, udf=0; tc forced 0 while rst_n low.
//  - Priority per cycle: reset > load > step > hold. Reset mid-count discards everything.
//  - tick = rst_n & enable & (pre_cnt >= prescale). On enable & !tick: pre_cnt+1.
//    On tick: pre_cnt<=0. enable low: pre_cnt holds. prescale lowered below pre_cnt
//    -> next enabled cycle ticks (>= compare).
//  - load: count <= (load_value > modulus) ? modulus : load_value; pre_cnt<=0; no step,
//    tc=0, flags unchanged (except clr_flags).
//  - Step (tick & !load), up: count<modulus -> count+1. count>=modulus -> wrap: 0,
//    saturate: modulus; ovf<=1.
//  - Step, down: count==0 -> wrap: modulus, saturate: 0; udf<=1.
//    count>modulus -> modulus (no flag). Else count-1.
//  - tc = tick & !load & (dir ? count>=modulus : count==0); 1-cycle, 0 latency.
//  - modulus==0: count stays 0; every step raises tc and ovf/udf per dir.
//  - Arithmetic in WIDTH bits, no carry out; count never exceeds modulus after a step/load.
//  - clr_flags same cycle as a set event: set wins (flag ends 1).
//  - dir/saturate/modulus sampled every cycle; changes take effect on the next step.
// STRUCTURE
//  - counter_pkg: localparams DIR_DOWN=0, DIR_UP=1, MODE_WRAP=0, MODE_SAT=1.
//  - Sub-module tick_prescaler (PRE_W): clk, rst_n, enable, clear(load), prescale -> tick.
//  - Top: count register, next-count mux, tc decode, flag registers.
// TESTING
//  1 Reset: drive rst_n=0 two cycles mid-count at count=5 -> count=0, ovf=udf=0, tc=0;
//    rst_n=0 without posedge does not clear.
//  2 Wrap up: WIDTH=8, modulus=9, prescale=0, dir=1, enable=1 -> 0..9,0; tc high in the
//    cycle count==9; ovf=1 after.
//  3 Saturate down: load_value=2, saturate=1, dir=0 -> 2,1,0,0,0; tc high each cycle at 0;
//    udf=1; clr_flags with concurrent step -> udf stays 1.
//  4 Prescaler: prescale=3 -> count advances every 4th enabled cycle; enable gaps stretch
//    period; load mid-period restarts 4-cycle interval.
//  5 Load clamp / priority: modulus=20, load=1, load_value=200 with tick -> count=20,
//    tc=0; then up step wraps to 0.
//  6 modulus change: count=15, modulus set 10, dir=1 -> next step 0 (wrap) or 10 (sat),
//    tc=1, ovf=1.

Source files
------------

// File: rtl/counter_prog_pkg.sv
// counter_prog_pkg: shared constants and types for the programmable counter.
// Direction and mode encodings match the dir/saturate input pins.
package counter_prog_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // What the count register does in a given cycle, after priority resolution.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STEP_UP,
    ACT_STEP_DOWN
  } action_e;

endpackage : counter_prog_pkg

// File: rtl/counter_prog_if.sv
// counter_prog_if: control and status bundle of the programmable counter.
// The master side (system or bench) drives the controls, the counter answers
// with its count, terminal-count strobe and sticky flags.
interface counter_prog_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             dir;
  logic             saturate;
  logic [WIDTH-1:0] modulus;
  logic [PRE_W-1:0] prescale;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             udf;

  modport master (
    output enable, load, load_value, dir, saturate, modulus, prescale, clr_flags,
    input  count, tc, ovf, udf
  );

  modport slave (
    input  enable, load, load_value, dir, saturate, modulus, prescale, clr_flags,
    output count, tc, ovf, udf
  );

endinterface : counter_prog_if

// File: rtl/counter_prog_tick_prescaler.sv
// tick_prescaler: divides enabled cycles by (prescale+1) and emits a
// one-cycle tick. The >= compare means lowering prescale below the current
// phase makes the very next enabled cycle tick instead of rolling over.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [PRE_W-1:0] i_prescale,
  output logic             o_tick
);

  logic [PRE_W-1:0] r_preCnt;
  logic             w_reached;

  assign w_reached = (r_preCnt >= i_prescale);
  assign o_tick    = i_rst_n & i_enable & w_reached;

  // Prescaler phase: restart on reset or clear, advance only while enabled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_preCnt <= '0;
    end else if (i_clear) begin
      r_preCnt <= '0;
    end else if (i_enable) begin
      if (o_tick) begin
        r_preCnt <= '0;
      end else begin
        r_preCnt <= r_preCnt + PRE_W'(1);
      end
    end
  end

endmodule : tick_prescaler

// File: rtl/counter_prog.sv
// counter_prog: programmable up/down counter with modulus, prescaler,
// synchronous load, wrap/saturate mode, terminal-count strobe and sticky
// overflow/underflow flags. Reset > load > step > hold.
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  counter_prog_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_tick;
  logic             w_atTop;
  logic             w_atZero;
  logic             w_satMode;
  logic             w_ovfSet;
  logic             w_udfSet;
  logic [WIDTH-1:0] w_loadClamped;
  logic [WIDTH-1:0] w_countNext;
  action_e          w_action;

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (bus.enable),
    .i_clear    (bus.load),
    .i_prescale (bus.prescale),
    .o_tick     (w_tick)
  );

  assign w_atTop       = (r_count >= bus.modulus);
  assign w_atZero      = (r_count == '0);
  assign w_satMode     = (bus.saturate == MODE_SAT);
  assign w_loadClamped = (bus.load_value > bus.modulus) ? bus.modulus : bus.load_value;

  // Resolve what the count does this cycle; load suppresses a coincident tick.
  always_comb begin
    w_action = ACT_HOLD;
    if (bus.load) begin
      w_action = ACT_LOAD;
    end else if (w_tick) begin
      w_action = (bus.dir == DIR_UP) ? ACT_STEP_UP : ACT_STEP_DOWN;
    end
  end

  // Next-count mux; a count above a freshly lowered modulus snaps to the limit.
  always_comb begin
    w_countNext = r_count;
    unique case (w_action)
      ACT_LOAD: begin
        w_countNext = w_loadClamped;
      end
      ACT_STEP_UP: begin
        if (w_atTop) begin
          w_countNext = w_satMode ? bus.modulus : '0;
        end else begin
          w_countNext = r_count + WIDTH'(1);
        end
      end
      ACT_STEP_DOWN: begin
        if (w_atZero) begin
          w_countNext = w_satMode ? '0 : bus.modulus;
        end else if (r_count > bus.modulus) begin
          w_countNext = bus.modulus;
        end else begin
          w_countNext = r_count - WIDTH'(1);
        end
      end
      default: begin
        w_countNext = r_count;
      end
    endcase
  end

  assign w_ovfSet = (w_action == ACT_STEP_UP)   & w_atTop;
  assign w_udfSet = (w_action == ACT_STEP_DOWN) & w_atZero;

  // Count and sticky flags; a set event in the same cycle beats clr_flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_countNext;
      if (w_ovfSet) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_udfSet) begin
        r_udf <= 1'b1;
      end else if (bus.clr_flags) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = w_ovfSet | w_udfSet;
  assign bus.ovf   = r_ovf;
  assign bus.udf   = r_udf;

endmodule : counter_prog

// File: tb/tb_counter_prog.sv
// tb_counter_prog: self-checking bench for counter_prog (WIDTH=8, PRE_W=4).
// A cycle model predicts each post-edge state into a scoreboard queue, which
// is popped and compared after the edge; tc is compared before the edge.
`timescale 1ns/1ps
module tb_counter_prog;
  import counter_prog_pkg::*;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             udf;
  } exp_t;

  logic i_clk;
  logic r_rstN;

  counter_prog_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  counter_prog #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (r_rstN),
    .bus     (bus)
  );

  exp_t             scoreQ[$];
  int               assertCount = 0;
  int               failCount   = 0;
  bit               modelValid  = 0;
  logic [WIDTH-1:0] mCount = '0;
  logic [PRE_W-1:0] mPre   = '0;
  logic             mOvf   = 1'b0;
  logic             mUdf   = 1'b0;

  // Free-running clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drive all inputs at the falling edge.
  task automatic setInputs(input logic rst, input logic en, input logic ld,
                           input logic [WIDTH-1:0] lv, input logic dr, input logic sat,
                           input logic [WIDTH-1:0] md, input logic [PRE_W-1:0] pre,
                           input logic clr);
    @(negedge i_clk);
    r_rstN         = rst;
    bus.enable     = en;
    bus.load       = ld;
    bus.load_value = lv;
    bus.dir        = dr;
    bus.saturate   = sat;
    bus.modulus    = md;
    bus.prescale   = pre;
    bus.clr_flags  = clr;
  endtask

  // Predict this cycle, check tc, cross the edge, then check the scoreboard.
  task automatic runCycle();
    logic             tk, st, expTc;
    logic [WIDTH-1:0] nC;
    logic [PRE_W-1:0] nP;
    logic             nO, nU;
    exp_t             e;
    #1;
    tk    = r_rstN && bus.enable && (mPre >= bus.prescale);
    st    = tk && !bus.load;
    expTc = st && (bus.dir ? (mCount >= bus.modulus) : (mCount == 0));
    checkOutput("tc", {31'd0, bus.tc}, {31'd0, expTc});
    if (modelValid) checkOutput("countBeforeEdge", {24'd0, bus.count}, {24'd0, mCount});
    nC = mCount; nP = mPre; nO = mOvf; nU = mUdf;
    if (!r_rstN) begin
      nC = '0; nP = '0; nO = 1'b0; nU = 1'b0;
    end else begin
      if (bus.clr_flags) begin nO = 1'b0; nU = 1'b0; end
      if (bus.load) begin
        nC = (bus.load_value > bus.modulus) ? bus.modulus : bus.load_value;
        nP = '0;
      end else begin
        if (bus.enable) nP = tk ? '0 : mPre + 1'b1;
        if (st && bus.dir) begin
          if (mCount >= bus.modulus) begin
            nC = bus.saturate ? bus.modulus : '0;
            nO = 1'b1;
          end else nC = mCount + 1'b1;
        end else if (st) begin
          if (mCount == 0) begin
            nC = bus.saturate ? '0 : bus.modulus;
            nU = 1'b1;
          end else if (mCount > bus.modulus) nC = bus.modulus;
          else nC = mCount - 1'b1;
        end
      end
    end
    mCount = nC; mPre = nP; mOvf = nO; mUdf = nU;
    if (!r_rstN) modelValid = 1;
    scoreQ.push_back('{count: nC, ovf: nO, udf: nU});
    @(posedge i_clk);
    #1;
    checkOutput("scoreQDepth", scoreQ.size(), 1);
    if (scoreQ.size() != 0) begin
      e = scoreQ.pop_front();
      if (modelValid) begin
        checkOutput("count", {24'd0, bus.count}, {24'd0, e.count});
        checkOutput("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        checkOutput("udf", {31'd0, bus.udf}, {31'd0, e.udf});
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                               input logic [WIDTH-1:0] lv, input logic dr, input logic sat,
                               input logic [WIDTH-1:0] md, input logic [PRE_W-1:0] pre,
                               input logic clr);
    setInputs(rst, en, ld, lv, dr, sat, md, pre, clr);
    runCycle();
  endtask

  // Directed scenarios followed by a randomized soak against the model.
  initial begin
    r_rstN = 1'b0;
    bus.enable = 0; bus.load = 0; bus.load_value = '0; bus.dir = DIR_UP;
    bus.saturate = MODE_WRAP; bus.modulus = 8'd9; bus.prescale = '0; bus.clr_flags = 0;

    $display("[TB] initial reset");
    repeat (2) applyStimulus(0, 0, 0, 0, DIR_UP, MODE_WRAP, 9, 0, 0);
    checkOutput("resetCount", {24'd0, bus.count}, 0);
    checkOutput("resetOvf", {31'd0, bus.ovf}, 0);

    $display("[TB] wrap up modulus 9");
    repeat (10) applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 0, 0);
    checkOutput("wrapToZero", {24'd0, bus.count}, 0);
    checkOutput("wrapOvf", {31'd0, bus.ovf}, 1);

    $display("[TB] reset mid-count");
    repeat (5) applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 0, 0);
    setInputs(0, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 0, 0);
    #1;
    checkOutput("noClearWithoutEdge", {24'd0, bus.count}, 5);
    checkOutput("tcInReset", {31'd0, bus.tc}, 0);
    runCycle();
    applyStimulus(0, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 0, 0);
    checkOutput("midResetCount", {24'd0, bus.count}, 0);
    checkOutput("midResetOvf", {31'd0, bus.ovf}, 0);
    checkOutput("midResetUdf", {31'd0, bus.udf}, 0);

    $display("[TB] saturate down");
    applyStimulus(1, 1, 1, 2, DIR_DOWN, MODE_SAT, 9, 0, 0);
    checkOutput("loadTwo", {24'd0, bus.count}, 2);
    repeat (4) applyStimulus(1, 1, 0, 0, DIR_DOWN, MODE_SAT, 9, 0, 0);
    checkOutput("satHoldZero", {24'd0, bus.count}, 0);
    checkOutput("satUdf", {31'd0, bus.udf}, 1);
    applyStimulus(1, 1, 0, 0, DIR_DOWN, MODE_SAT, 9, 0, 1);
    checkOutput("setBeatsClear", {31'd0, bus.udf}, 1);
    applyStimulus(1, 1, 0, 0, DIR_UP, MODE_SAT, 9, 0, 1);
    checkOutput("clearUdf", {31'd0, bus.udf}, 0);

    $display("[TB] prescaler");
    applyStimulus(1, 1, 1, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    repeat (8) applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    checkOutput("preEightCycles", {24'd0, bus.count}, 2);
    repeat (3) applyStimulus(1, 0, 0, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    repeat (2) applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    applyStimulus(1, 1, 1, 5, DIR_UP, MODE_WRAP, 9, 3, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    checkOutput("preRestartHold", {24'd0, bus.count}, 5);
    applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 9, 3, 0);
    checkOutput("preRestartStep", {24'd0, bus.count}, 6);

    $display("[TB] load clamp and priority");
    setInputs(1, 1, 1, 200, DIR_UP, MODE_WRAP, 20, 0, 1);
    #1;
    checkOutput("tcDuringLoad", {31'd0, bus.tc}, 0);
    runCycle();
    checkOutput("loadClamp", {24'd0, bus.count}, 20);
    applyStimulus(1, 1, 0, 0, DIR_UP, MODE_WRAP, 20, 0, 0);
    checkOutput("clampThenWrap", {24'd0, bus.count}, 0);
    checkOutput("clampWrapOvf", {31'd0, bus.ovf}, 1);

    $display("[TB] modulus lowered below count");
    applyStimulus(1, 1, 1, 15, DIR_UP, MODE_WRAP, 20, 0, 1);
    setInputs(1, 1, 0, 0, DIR_UP, MODE_WRAP, 10, 0, 0);
    #1;
    checkOutput("tcAboveModulus", {31'd0, bus.tc}, 1);
    runCycle();
    checkOutput("modLowerWrap", {24'd0, bus.count}, 0);
    checkOutput("modLowerOvf", {31'd0, bus.ovf}, 1);
    applyStimulus(1, 1, 1, 15, DIR_UP, MODE_SAT, 20, 0, 1);
    applyStimulus(1, 1, 0, 0, DIR_UP, MODE_SAT, 10, 0, 0);
    checkOutput("modLowerSat", {24'd0, bus.count}, 10);

    $display("[TB] modulus zero");
    applyStimulus(1, 1, 1, 7, DIR_DOWN, MODE_WRAP, 0, 0, 1);
    checkOutput("modZeroLoad", {24'd0, bus.count}, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, DIR_DOWN, MODE_WRAP, 0, 0, 0);
    checkOutput("modZeroCount", {24'd0, bus.count}, 0);
    checkOutput("modZeroUdf", {31'd0, bus.udf}, 1);

    $display("[TB] randomized soak");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0),
                    WIDTH'($urandom_range(0, 40)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    WIDTH'($urandom_range(0, 30)),
                    PRE_W'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_counter_prog
